// File: rtl/shift_pkg.sv
// Shared definitions for the shift-register family.
// FSM encodings and default word width.
`timescale 1ns/1ps
package shift_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int WIDTH_DEF = 8;

endpackage

// File: rtl/shift_register_piso.sv
// Parallel-in serial-out shifter, MSB first.
// Back-to-back words, outputs decoded from flops only.
`timescale 1ns/1ps
module shift_register_piso
    import shift_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             C,
    input  logic             CLR_N,
    input  logic [WIDTH-1:0] PI,
    input  logic             LOAD,
    output logic             READY,
    output logic             SO,
    output logic             SO_VALID,
    output logic             DONE
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic last_bit;

    assign last_bit = (cnt_q == '0);

    // State, shifter and counter registers with synchronous clear.
    always_ff @(posedge C) begin
        if (!CLR_N) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: accept, shift, reload on the last bit, or drop to idle.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (LOAD) begin
                    sreg_d  = PI;
                    cnt_d   = CNT_TOP;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!last_bit) begin
                    sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
                    cnt_d  = cnt_q - CW'(1);
                end else if (LOAD) begin
                    sreg_d = PI;
                    cnt_d  = CNT_TOP;
                end else begin
                    sreg_d  = '0;
                    state_d = IDLE;
                end
            end
        endcase
    end

    // Outputs come only from registered state.
    always_comb begin
        SO_VALID = (state_q == SHIFT);
        SO       = SO_VALID && sreg_q[WIDTH-1];
        DONE     = SO_VALID && last_bit;
        READY    = !SO_VALID || last_bit;
    end

endmodule
